// File: rtl/pulse_gen_pkg.sv
// Shared types and default widths for the pulse-train generator.
package pulse_gen_pkg;
  localparam int PG_CNT_W = 8;
  localparam int PG_LEN_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    DONE = 2'd3
  } pg_state_t;
endpackage

// File: rtl/pulse_gen_timer.sv
// Loadable phase down-counter; a load of 0 behaves as 1, expire_o flags the last cycle.
module pulse_gen_timer #(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [LEN_W-1:0] load_val_i,
  output logic             expire_o
);
  logic [LEN_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i)
      count_d = (load_val_i == '0) ? LEN_W'(1) : load_val_i;
    else if (count_q > LEN_W'(1))
      count_d = count_q - LEN_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign expire_o = (count_q == LEN_W'(1));
endmodule

// File: rtl/pulse_gen.sv
// Pulse-train generator feeding the event counter's num_i.
// Optional auto-repeat of the latched burst is enabled with PULSE_GEN_REPEAT_EN.
module pulse_gen
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W = PG_CNT_W,
  parameter int LEN_W = PG_LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [CNT_W-1:0] num_pulses_i,
  input  logic [LEN_W-1:0] high_len_i,
  input  logic [LEN_W-1:0] low_len_i,
  input  logic             abort_i,
`ifdef PULSE_GEN_REPEAT_EN
  input  logic             repeat_i,
`endif
  output logic             num_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] sent_o
);
  pg_state_t        state_q, state_d;
  logic [CNT_W-1:0] npulse_q, npulse_d;
  logic [LEN_W-1:0] hlen_q, hlen_d;
  logic [LEN_W-1:0] llen_q, llen_d;
  logic [CNT_W-1:0] sent_q, sent_d;
  logic             num_q;
  logic             tmr_load;
  logic [LEN_W-1:0] tmr_val;
  logic             tmr_exp;

  pulse_gen_timer #(.LEN_W(LEN_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expire_o   (tmr_exp)
  );

  always_comb begin
    state_d  = state_q;
    npulse_d = npulse_q;
    hlen_d   = hlen_q;
    llen_d   = llen_q;
    sent_d   = sent_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      IDLE: if (start_i) begin
        npulse_d = num_pulses_i;
        hlen_d   = high_len_i;
        llen_d   = low_len_i;
        sent_d   = '0;
        if (num_pulses_i == '0) begin
          state_d = DONE;
        end else begin
          state_d  = HIGH;
          tmr_load = 1'b1;
          tmr_val  = high_len_i;
        end
      end
      HIGH: if (tmr_exp) begin
        sent_d   = sent_q + CNT_W'(1);
        tmr_load = 1'b1;
        tmr_val  = llen_q;
        state_d  = LOW;
      end
      // Last pulse also gets its full low phase before DONE.
      LOW: if (tmr_exp) begin
        if (sent_q == npulse_q) begin
          state_d = DONE;
        end else begin
          tmr_load = 1'b1;
          tmr_val  = hlen_q;
          state_d  = HIGH;
        end
      end
      DONE: begin
`ifdef PULSE_GEN_REPEAT_EN
        if (repeat_i) begin
          sent_d = '0;
          if (npulse_q != '0) begin
            tmr_load = 1'b1;
            tmr_val  = hlen_q;
            state_d  = HIGH;
          end
        end else begin
          state_d = IDLE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
    // Abort overrides everything but reset; sent count is kept as a partial.
    if (abort_i && state_q != IDLE) begin
      state_d  = IDLE;
      sent_d   = sent_q;
      tmr_load = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      npulse_q <= '0;
      hlen_q   <= '0;
      llen_q   <= '0;
      sent_q   <= '0;
      num_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      npulse_q <= npulse_d;
      hlen_q   <= hlen_d;
      llen_q   <= llen_d;
      sent_q   <= sent_d;
      num_q    <= (state_d == HIGH);
    end
  end

  assign num_o  = num_q;
  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == DONE);
  assign sent_o = sent_q;
endmodule

// File: doc/pulse_gen.md
# pulse_gen

Pulse-train generator that drives the `num_i` input of the 8-bit event counter. It is the transmit end of the counter's pulse interface. On a start request it emits a programmed number of clean high/low pulses with programmable phase lengths, then reports completion. Benches and on-chip self-test use it to stimulate the counter, including deterministic overflow of `of`/`cnt`.

## Interface
Parameters:
- `CNT_W`, default 8: pulse-count width; matches the counter's `cnt` width.
- `LEN_W`, default 4: phase-length width, in clock cycles.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start_i`  in  1  begin burst; honoured only in IDLE.
- `num_pulses_i`  in  CNT_W  pulses per burst; captured at start.
- `high_len_i`  in  LEN_W  high-phase cycles; captured at start; 0 is treated as 1.
- `low_len_i`  in  LEN_W  low-phase cycles; captured at start; 0 is treated as 1.
- `abort_i`  in  1  terminate burst immediately.
- `num_o`  out  1  pulse output; registered; connects to the counter's `num_i`.
- `busy_o`  out  1  high in HIGH, LOW and DONE.
- `done_o`  out  1  one-cycle strobe at burst completion.
- `sent_o`  out  CNT_W  pulses completed in the current or last burst.

## Operation
- FSM states: IDLE, HIGH, LOW, DONE.
- **IDLE**
  - On `start_i`, latch `num_pulses_i`, `high_len_i` and `low_len_i`, and clear `sent_o`.
  - If the latched count is 0, go to DONE.
  - Otherwise go to HIGH with the phase timer loaded to `high_len`.
- **HIGH**
  - `num_o` = 1.
  - When the timer expires: increment `sent_o`, load the timer with `low_len`, go to LOW.
- **LOW**
  - `num_o` = 0.
  - When the timer expires: if `sent_o` == latched count, go to DONE; otherwise load `high_len` and go to HIGH.
  - Every pulse, including the last, is followed by a full low phase.
- **DONE**
  - `done_o` = 1 for exactly one cycle, then go to IDLE.
- `start_i` outside IDLE is ignored and is not queued.
- `sent_o` holds its value after DONE until the next accepted start.
- `abort_i` has priority over every transition except `rst`.
  - In any non-IDLE state it forces IDLE on the next edge, with `num_o` = 0.
  - No `done_o` is generated; `sent_o` holds the partial count.
- Arithmetic:
  - `sent_o` never exceeds the latched count, so it cannot wrap.
  - A count of 2^CNT_W − 1 is legal.
- Reset values: `num_o` = 0, `busy_o` = 0, `done_o` = 0, `sent_o` = 0, state IDLE, latched config 0.

## Timing
- `start_i` sampled high at edge E:
  - `num_o` = 1 and `busy_o` = 1 in the cycle after E.
- Pulse period is `high_len + low_len` cycles.
- Burst of N > 0 pulses:
  - `busy_o` is high for N·(H+L)+1 cycles.
  - `done_o` is high in the last of those cycles.
  - IDLE is re-entered the following cycle; the earliest new start is sampled at the end of that cycle.
- N = 0: `done_o` is high in the cycle after E; `busy_o` is high for that one cycle.
- `rst` at any time: all outputs take their reset values in the cycle after the sampling edge, overriding `start_i` and `abort_i`.
- `abort_i` and the final timer expiry in the same cycle: abort wins; no `done_o`.

## Configuration
- Macro `PULSE_GEN_REPEAT_EN`.
- Defined:
  - Adds input port `repeat_i` (1 bit).
  - When `repeat_i` = 1 in DONE, the FSM returns directly to HIGH (or stays in DONE for N = 0) using the same latched configuration, and `sent_o` restarts from 0.
  - `done_o` still strobes once per burst, and `busy_o` stays high.
  - `abort_i` and `rst` stop repetition.
- Not defined:
  - `repeat_i` is absent; every burst requires a new `start_i`.

## Structure
- Package `pulse_gen_pkg`:
  - State enum `pg_state_t` (IDLE, HIGH, LOW, DONE).
  - Default width constants `PG_CNT_W` = 8 and `PG_LEN_W` = 4.
- Sub-module `pulse_gen_timer`:
  - LEN_W-bit loadable down-counter; a load of 0 is treated as 1.
  - Outputs an `expire` flag when the count reaches 1.
  - Used for both phases.

## Test plan
- N=3, H=1, L=1, start at edge 0:
  - `num_o` in cycles 1–6 is 1,0,1,0,1,0.
  - `done_o` = 1 in cycle 7 only.
  - `sent_o` = 3; `busy_o` is low from cycle 8.
- N=0: `done_o` = 1 in cycle 1, `num_o` stays 0, `sent_o` = 0.
- N=255, H=2, L=3, driving the counter:
  - 255 rising edges on `num_o`.
  - `done_o` in cycle 1276.
  - Counter `cnt` = 255 with no `of`.
  - A second burst of N=1 sets `of`.
- `start_i` pulsed mid-burst (N=4, H=2, L=2, at cycle 5):
  - Ignored; the burst completes normally with `sent_o` = 4.
- `abort_i` in cycle 4 of N=5, H=1, L=1:
  - `num_o` = 0 and IDLE from cycle 5.
  - No `done_o`; `sent_o` = 2.
- `rst` held high for one cycle mid-burst:
  - All outputs are 0 in the next cycle.
  - A start sampled after `rst` deasserts produces a correct fresh burst.
